tanh_scheduler: RTL and testbench

Time-multiplexes one shared fixed-point tanh engine (CORDIC tanh + divider, S8.24 format) among `N_REQ` p-bit update requesters. Round-robin arbitration selects a request and captures its argument. The block then pulses the engine's load/enable, waits a fixed engine latency, and captures the engine output. It returns the result with a one-cycle done pulse addressed to the requester. It sits between the p-bit array and the single tanh engine instance.

---
 rtl/tanh_scheduler_if.sv | 25 ++
 rtl/tanh_scheduler.sv | 143 ++++++++++++++
 tb/tb_tanh_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tanh_scheduler_if.sv
// Requester-side bus of the shared tanh engine scheduler: level requests with
// packed arguments in, one-hot completion pulse with result and owner index out.
interface tanh_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int W     = 32
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] z_in;
  logic [N_REQ-1:0]   done;
  logic [W-1:0]       res;
  logic [ID_W-1:0]    res_id;
  logic               busy;

  modport master (
    output req, z_in,
    input  done, res, res_id, busy
  );

  modport slave (
    input  req, z_in,
    output done, res, res_id, busy
  );
endinterface

// File: rtl/tanh_scheduler.sv
// Round-robin time-multiplexer of N_REQ requesters onto one fixed-latency tanh engine.
// Each grant loads the engine once, waits TANH_LATENCY cycles, then returns the result with a done pulse.
module tanh_scheduler #(
  parameter int N_REQ        = 4,
  parameter int INT_SIZE     = 8,
  parameter int FLOAT_SIZE   = 24,
  parameter int TANH_LATENCY = 64,
  localparam int W           = INT_SIZE + FLOAT_SIZE,
  localparam int ID_W        = $clog2(N_REQ),
  localparam int CNT_W       = $clog2(TANH_LATENCY + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  tanh_scheduler_if.slave       sched,
  output logic                  eng_en,
  output logic [W-1:0]          eng_z,
  input  logic [W-1:0]          eng_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;

  logic [ID_W-1:0]   sel_reg;
  logic [ID_W-1:0]   last_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [W-1:0]      eng_z_reg;
  logic [W-1:0]      res_reg;
  logic [ID_W-1:0]   res_id_reg;
  logic [N_REQ-1:0]  done_reg;
  logic              busy_reg;
  logic              eng_en_reg;

  logic [W-1:0]      z_arr [N_REQ];
  logic [ID_W-1:0]   cand_idx [N_REQ];
  logic [ID_W-1:0]   winner;
  logic              grant_found;
  logic              run_last;

  assign run_last = (state_reg == RUN) && (cnt_reg == '0);

  // cand_idx[k] is the requester examined k-th, starting just after the last winner.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign z_arr[gi]    = sched.z_in[gi*W +: W];
      assign cand_idx[gi] = ID_W'((int'(last_reg) + gi + 1) % N_REQ);
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (sched.req[cand_idx[i]]) begin
        grant_found = 1'b1;
        winner      = cand_idx[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // eng_en and busy are registered from the next state so they line up with LOAD and non-IDLE cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= IDLE;
      eng_en_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      eng_en_reg <= (state_next == LOAD);
      busy_reg   <= (state_next != IDLE);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_reg   <= '0;
      last_reg  <= ID_W'(N_REQ - 1);
      eng_z_reg <= '0;
    end else if ((state_reg == IDLE) && grant_found) begin
      sel_reg   <= winner;
      last_reg  <= winner;
      eng_z_reg <= z_arr[winner];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg <= '0;
    end else if (state_reg == LOAD) begin
      cnt_reg <= CNT_W'(TANH_LATENCY - 1);
    end else if ((state_reg == RUN) && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_reg    <= '0;
      res_id_reg <= '0;
    end else if (run_last) begin
      res_reg    <= eng_out;
      res_id_reg <= sel_reg;
    end
  end

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_done
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          done_reg[gi] <= 1'b0;
        end else begin
          done_reg[gi] <= run_last && (sel_reg == ID_W'(gi));
        end
      end
    end
  endgenerate

  assign sched.done   = done_reg;
  assign sched.res    = res_reg;
  assign sched.res_id = res_id_reg;
  assign sched.busy   = busy_reg;
  assign eng_en       = eng_en_reg;
  assign eng_z        = eng_z_reg;

endmodule

// File: tb/tb_tanh_scheduler.sv
// Bench for tanh_scheduler: two instances (latency 64 and 1) with engine stubs, a
// transaction-timeline reference model per instance, directed steps and random traffic.
module tb_tanh_scheduler;
  localparam int N  = 4;
  localparam int IW = 8;
  localparam int FW = 24;
  localparam int W  = IW + FW;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [N-1:0]   req_s [2];
  logic [N*W-1:0] z_s   [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Round-robin rule: first set bit at (last+1), (last+2), ... modulo N.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++) begin
      if (r[(last + off) % N]) return (last + off) % N;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] z_slice(input logic [N*W-1:0] z, input int k);
    return z[k*W +: W];
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int L = (gi == 0) ? 64 : 1;

    tanh_scheduler_if #(.N_REQ(N), .W(W)) bus ();
    logic         eng_en;
    logic [W-1:0] eng_z;
    logic [W-1:0] eng_out;

    assign bus.req  = req_s[gi];
    assign bus.z_in = z_s[gi];

    tanh_scheduler #(
      .N_REQ(N), .INT_SIZE(IW), .FLOAT_SIZE(FW), .TANH_LATENCY(L)
    ) dut (
      .CLK(CLK), .RST_N(RST_N), .sched(bus),
      .eng_en(eng_en), .eng_z(eng_z), .eng_out(eng_out)
    );

    // Engine stub: garbage until L cycles after enable falls, then eng_z+1 held stable.
    int           s_cnt = 0;
    logic [W-1:0] s_val = '0;
    always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        eng_out <= '0;
        s_cnt   <= 0;
      end else if (eng_en) begin
        s_val   <= eng_z + 32'd1;
        s_cnt   <= L - 1;
        eng_out <= (L == 1) ? eng_z + 32'd1 : 32'hDEAD_BEEF;
      end else if (s_cnt > 0) begin
        s_cnt <= s_cnt - 1;
        if (s_cnt == 1) eng_out <= s_val;
      end
    end

    // Reference timeline: a grant at the end of cycle t owns the engine through cycle t+L+2.
    logic         m_busy     = 1'b0;
    int           m_last     = N - 1;
    longint       m_grant_c  = 0;
    longint       m_done_c   = 0;
    logic [W-1:0] m_res_pend = '0;
    logic [W-1:0] m_z_pend   = '0;
    logic [W-1:0] m_res      = '0;
    int           m_id_pend  = 0;
    int           m_id       = 0;
    int           obs_ids[$];
    longint       obs_done_c[$];
    wire          in_done = m_busy && (cyc == m_done_c);

    always @(posedge CLK) begin
      if (!RST_N) begin
        m_busy <= 1'b0;
        m_last <= N - 1;
      end else if (m_busy) begin
        if (cyc == m_done_c) m_busy <= 1'b0;
      end else if (req_s[gi] != '0) begin
        m_busy     <= 1'b1;
        m_last     <= rr_pick(req_s[gi], m_last);
        m_id_pend  <= rr_pick(req_s[gi], m_last);
        m_z_pend   <= z_slice(z_s[gi], rr_pick(req_s[gi], m_last));
        m_res_pend <= z_slice(z_s[gi], rr_pick(req_s[gi], m_last)) + 32'd1;
        m_grant_c  <= cyc;
        m_done_c   <= cyc + L + 2;
      end
    end

    always @(negedge CLK) begin
      if (!RST_N) begin
        chk($sformatf("i%0d_rst_done", gi),   bus.done,   '0);
        chk($sformatf("i%0d_rst_res", gi),    bus.res,    '0);
        chk($sformatf("i%0d_rst_res_id", gi), bus.res_id, '0);
        chk($sformatf("i%0d_rst_busy", gi),   bus.busy,   '0);
        chk($sformatf("i%0d_rst_eng_en", gi), eng_en,     '0);
        chk($sformatf("i%0d_rst_eng_z", gi),  eng_z,      '0);
        m_res <= '0;
        m_id  <= 0;
      end else begin
        chk($sformatf("i%0d_done", gi), bus.done, in_done ? (64'd1 << m_id_pend) : 64'd0);
        chk($sformatf("i%0d_busy", gi), bus.busy, 64'(m_busy));
        chk($sformatf("i%0d_eng_en", gi), eng_en, 64'(m_busy && (cyc == m_grant_c + 1)));
        if (in_done) begin
          chk($sformatf("i%0d_res", gi),    bus.res,    m_res_pend);
          chk($sformatf("i%0d_res_id", gi), bus.res_id, 64'(m_id_pend));
          m_res <= m_res_pend;
          m_id  <= m_id_pend;
        end else begin
          chk($sformatf("i%0d_res_hold", gi),    bus.res,    m_res);
          chk($sformatf("i%0d_res_id_hold", gi), bus.res_id, 64'(m_id));
        end
        if (m_busy) chk($sformatf("i%0d_eng_z", gi), eng_z, m_z_pend);
        if (bus.done != '0) begin
          obs_ids.push_back(int'(bus.res_id));
          obs_done_c.push_back(cyc);
        end
      end
    end
  end

  initial begin
    longint       t0;
    int           base;
    logic [W-1:0] zc;

    RST_N    = 1'b1;
    req_s[0] = '0;
    req_s[1] = '0;
    z_s[0]   = '0;
    z_s[1]   = '0;
    #1 RST_N = 1'b0;
    repeat (3) step();
    RST_N = 1'b1;

    // Idle stability for 100 cycles.
    repeat (100) step();
    chk("idle_busy", g_inst[0].bus.busy, '0);

    // Single request on index 2.
    z_s[0][2*W +: W] = 32'h0100_0000;
    req_s[0] = 4'b0100;
    t0 = cyc;
    for (int k = 0; k < 200 && g_inst[0].bus.done == '0; k++) step();
    chk("single_latency", 64'(cyc - t0), 64'd66);
    chk("single_done",    g_inst[0].bus.done,   64'h4);
    chk("single_res",     g_inst[0].bus.res,    64'h0100_0001);
    chk("single_res_id",  g_inst[0].bus.res_id, 64'd2);
    req_s[0] = '0;
    repeat (5) step();

    // Round-robin from fresh reset with all four requesting.
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    for (int k = 0; k < N; k++) z_s[0][k*W +: W] = $urandom;
    req_s[0] = 4'b1111;
    base = g_inst[0].obs_ids.size();
    for (int k = 0; k < 8*67 + 40 && g_inst[0].obs_ids.size() < base + 8; k++) step();
    req_s[0] = '0;
    chk("rr_count", 64'(g_inst[0].obs_ids.size() - base), 64'd8);
    if (g_inst[0].obs_ids.size() >= base + 8) begin
      for (int k = 0; k < 8; k++)
        chk($sformatf("rr_grant%0d", k), 64'(g_inst[0].obs_ids[base + k]), 64'(k % N));
    end
    repeat (80) step();

    // Argument capture: z1 changes and req[1] drops during RUN.
    zc = $urandom;
    z_s[0][W +: W] = zc;
    req_s[0] = 4'b0010;
    for (int k = 0; k < 10 && g_inst[0].eng_en == 1'b0; k++) step();
    repeat (6) step();
    z_s[0][W +: W] = ~zc;
    req_s[0] = '0;
    for (int k = 0; k < 100 && g_inst[0].bus.done == '0; k++) step();
    chk("cap_done", g_inst[0].bus.done, 64'h2);
    chk("cap_res",  g_inst[0].bus.res,  64'(zc + 32'd1));
    repeat (5) step();

    // Reset in RUN cycle 10, then index 3 served normally.
    z_s[0][0 +: W] = $urandom;
    req_s[0] = 4'b0001;
    for (int k = 0; k < 10 && g_inst[0].eng_en == 1'b0; k++) step();
    repeat (10) step();
    RST_N = 1'b0;
    #1;
    chk("mid_rst_done",   g_inst[0].bus.done,   '0);
    chk("mid_rst_busy",   g_inst[0].bus.busy,   '0);
    chk("mid_rst_res",    g_inst[0].bus.res,    '0);
    chk("mid_rst_eng_z",  g_inst[0].eng_z,      '0);
    chk("mid_rst_eng_en", g_inst[0].eng_en,     '0);
    step();
    step();
    zc = $urandom;
    z_s[0][3*W +: W] = zc;
    req_s[0] = 4'b1000;
    RST_N = 1'b1;
    for (int k = 0; k < 100 && g_inst[0].bus.done == '0; k++) step();
    chk("post_rst_done",   g_inst[0].bus.done,   64'h8);
    chk("post_rst_res_id", g_inst[0].bus.res_id, 64'd3);
    chk("post_rst_res",    g_inst[0].bus.res,    64'(zc + 32'd1));
    req_s[0] = '0;
    repeat (5) step();

    // Latency corner: TANH_LATENCY=1 with back-to-back requests.
    for (int k = 0; k < N; k++) z_s[1][k*W +: W] = $urandom;
    req_s[1] = 4'b0011;
    t0 = cyc;
    base = g_inst[1].obs_done_c.size();
    for (int k = 0; k < 100 && g_inst[1].obs_done_c.size() < base + 4; k++) step();
    req_s[1] = '0;
    chk("lat1_count", 64'(g_inst[1].obs_done_c.size() - base), 64'd4);
    if (g_inst[1].obs_done_c.size() >= base + 4) begin
      chk("lat1_first_done", 64'(g_inst[1].obs_done_c[base] - t0), 64'd3);
      for (int k = 1; k < 4; k++)
        chk($sformatf("lat1_spacing%0d", k),
            64'(g_inst[1].obs_done_c[base + k] - g_inst[1].obs_done_c[base + k - 1]), 64'd4);
    end
    repeat (5) step();

    // Random traffic on both instances against the reference timeline.
    for (int r = 0; r < 60; r++) begin
      req_s[0] = N'($urandom);
      req_s[1] = N'($urandom);
      for (int k = 0; k < N; k++) begin
        z_s[0][k*W +: W] = $urandom;
        z_s[1][k*W +: W] = $urandom;
      end
      repeat ($urandom_range(5, 40)) step();
    end
    req_s[0] = '0;
    req_s[1] = '0;
    repeat (80) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
